axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
AXI-Lite initiator that turns a simple single-outstanding command/response interface into AXI-Lite read and write transactions.
It drives any AXI-Lite responder in the design, including the team's 64-word memory slave, and is the host-side end used by test harnesses and control logic.
Exactly one transaction is in flight at a time. Each response reports the measured transaction latency.

Parameters:
ADDR_WIDTH, 8, byte address width
DATA_WIDTH, 32, data width; must be 32 (WSTRB is 4 bits)
CNT_WIDTH, 16, width of latency counter rsp_cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accept (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_cycles  out  CNT_WIDTH  clocks from command accept to rsp_valid, saturating
AWADDR  out  ADDR_WIDTH;  AWVALID out 1;  AWREADY in 1
WDATA  out  DATA_WIDTH;  WSTRB out 4;  WVALID out 1;  WREADY in 1
BVALID  in  1;  BREADY out 1
ARADDR  out  ADDR_WIDTH;  ARVALID out 1;  ARREADY in 1
RDATA  in  DATA_WIDTH;  RVALID in 1;  RREADY out 1

Behaviour:
- Reset (rst_n=0, async): state=IDLE; AWVALID=WVALID=ARVALID=BREADY=RREADY=rsp_valid=0.
  - Address, data and rsp registers are 0. rsp_cycles=0.
  - Any in-flight transaction is dropped.
  - cmd_ready=1 once in IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- IDLE: cmd_valid&&cmd_ready latches addr/wdata/wstrb/write and clears the counter to 0. Next state is WR_REQ or RD_REQ.
- WR_REQ: AWVALID and WVALID rise together on the first cycle.
  - Each channel deasserts independently the cycle after its own handshake (VALID&&READY); aw_done and w_done flags track this.
  - VALID is never dropped before its handshake; addr/data stay stable while VALID=1.
  - When both are done (same or different cycles), next state is WR_RESP.
- WR_RESP: BREADY=1. On BVALID, go to RSP. BVALID outside WR_RESP is ignored because BREADY=0.
- RD_REQ: ARVALID=1 until ARREADY, then RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA into rsp_rdata and go to RSP. RVALID outside RD_DATA is ignored.
- RSP: rsp_valid=1 and the counter frozen. Hold until rsp_ready, then IDLE.
  - cmd_ready returns the cycle after the response handshake, so the minimum command-to-command spacing is one idle cycle.
- Counter: increments every cycle from the accept edge until rsp_valid rises. Saturates at 2^CNT_WIDTH-1.
- Latency with zero-wait responder: write rsp_valid 3 cycles after accept (rsp_cycles=3); read likewise 3.
- Addresses pass through unmodified; alignment is the responder's concern. WSTRB=0 is still issued.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- Reset deassertion mid-stream: first accept possible on the first edge with rst_n=1.

Decomposition:
- Shared package axi_lite_pkg:
  - state enum typedef (mst_state_t)
  - ADDR_LSB = $clog2(DATA_WIDTH/8)
  - default ADDR_WIDTH/DATA_WIDTH constants
  - the same package is used by the slave and the bench
- One sub-module, sat_counter (parameter WIDTH; inputs clr, en; output count, saturating), instantiated for rsp_cycles.

Test Plan:
- Write, zero-wait responder: cmd addr=0x10 wdata=0xDEADBEEF wstrb=0xF -> AW/W handshake cycle 1, BREADY handshake, rsp_valid with rsp_write=1 and rsp_cycles=3; readback of 0x10 gives rsp_rdata=0xDEADBEEF.
- Partial strobe: write 0x11223344 full, then 0xAABBCCDD with wstrb=0x5 at addr 0x04 -> read returns 0x11BB33DD.
- Skewed channels: AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles with stable AWADDR; single BREADY handshake; rsp_cycles=7.
- Backpressure: rsp_ready held low 10 cycles after read of 0x20 -> rsp_valid, rsp_rdata and rsp_cycles stable; cmd_ready=0 and a cmd_valid pulse is ignored; no ARVALID issued.
- Reset mid-write: assert rst_n=0 while AWVALID=1 and BREADY not yet reached -> all VALID/READY outputs 0 within the same cycle (async); after release cmd_ready=1 and a new read completes normally.
- Spurious responder: BVALID=1 and RVALID=1 driven while IDLE -> BREADY=RREADY=0, no rsp_valid, state stays IDLE.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions for the master, the memory slave and benches.
// - mst_state_t    : master FSM state encoding
// - DEF_ADDR_WIDTH : default byte-address width
// - DEF_DATA_WIDTH : default data width (32, four byte lanes)
// - ADDR_LSB       : low address bits that select a byte within a word
package axi_lite_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned ADDR_LSB       = $clog2(DEF_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } mst_state_t;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels).
// - master modport : drives addresses, data, VALIDs on requests, READYs on responses
// - slave modport  : the mirror image, for responders
interface axi_lite_master_if
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
// - clk, rst_n : clock, asynchronous active-low reset (count -> 0)
// - clr        : synchronous clear to 0, has priority over en
// - en         : increment by one, holding at all-ones
// - count      : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: one command in, one AXI-Lite transaction out, one response back.
// - clk, rst_n        : clock, asynchronous active-low reset
// - cmd_*             : command request (valid/ready, write flag, addr, wdata, wstrb)
// - rsp_*             : response (valid/ready, write echo, read data, latency in clocks)
// - axi               : AXI-Lite master bus
// Only one transaction is ever in flight. Every output comes from a register or from
// the state register, so there is no input-to-output combinational path.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [CNT_WIDTH-1:0]    rsp_cycles,
    axi_lite_master_if.master       axi
);

    mst_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    write_q, write_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic cnt_en;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    // Each write channel drops its VALID the cycle after its own handshake.
    assign axi.awvalid = (state_q == StWrReq) && !aw_done_q;
    assign axi.wvalid  = (state_q == StWrReq) && !w_done_q;
    assign axi.bready  = (state_q == StWrResp);
    assign axi.arvalid = (state_q == StRdReq);
    assign axi.rready  = (state_q == StRdData);
    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;

    assign rsp_valid = (state_q == StRsp);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    state_d   = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrResp;
            end
            StWrResp: begin
                if (axi.bvalid) state_d = StRsp;
            end
            StRdReq: begin
                if (axi.arready) state_d = StRdData;
            end
            StRdData: begin
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
        end
    end

    // Counts every edge while a transaction is on the bus, including the edge that
    // enters StRsp; it is cleared on the accept edge and frozen in StRsp/StIdle.
    assign cnt_en = (state_q != StIdle) && (state_q != StRsp);

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_lat_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (cnt_en),
        .count(rsp_cycles)
    );

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a 64-word AXI-Lite memory responder that
// captures a request on its handshake and answers one clock later.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int unsigned CW = 4;  // narrow counter so saturation is reachable

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_write;
    logic [DW-1:0]   rsp_rdata;
    logic [CW-1:0]   rsp_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_cycles(rsp_cycles),
        .axi       (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- responder ----------------
    logic [DW-1:0]   mem [64];
    logic            aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
    logic            ar_got = 1'b0, r_pend = 1'b0;
    logic [AW-1:0]   s_waddr = '0, s_raddr = '0;
    logic [DW-1:0]   s_wdata = '0, s_rdata = '0;
    logic [DW/8-1:0] s_wstrb = '0;
    int              aw_cnt = 0;
    int              aw_wait = 0;
    logic            spur_b = 1'b0, spur_r = 1'b0;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_wait);
    assign bus.wready  = 1'b1;
    assign bus.bvalid  = b_pend || spur_b;
    assign bus.arready = bus.arvalid;
    assign bus.rvalid  = r_pend || spur_r;
    assign bus.rdata   = s_rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            ar_got <= 1'b0; r_pend <= 1'b0; aw_cnt <= 0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1'b1; s_waddr <= bus.awaddr; aw_cnt <= 0;
            end else if (bus.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (bus.wvalid && bus.wready) begin
                w_got <= 1'b1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb;
            end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) mem[s_waddr[ADDR_LSB +: 6]][8*i +: 8] <= s_wdata[8*i +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
            end
            if (b_pend && bus.bready) b_pend <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                ar_got <= 1'b1; s_raddr <= bus.araddr;
            end
            if (ar_got) begin
                r_pend <= 1'b1; s_rdata <= mem[s_raddr[ADDR_LSB +: 6]]; ar_got <= 1'b0;
            end
            if (r_pend && bus.rready) r_pend <= 1'b0;
        end
    end

    // ---------------- bus monitor (sampled mid-cycle) ----------------
    int mon_aw = 0, mon_w = 0, mon_b = 0, mon_ar = 0, mon_r = 0, mon_unstable = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    always @(negedge clk) begin
        if (bus.awvalid) begin
            mon_aw++;
            if (bus.awaddr !== exp_addr) mon_unstable++;
        end
        if (bus.wvalid) begin
            mon_w++;
            if (bus.wdata !== exp_wdata) mon_unstable++;
        end
        if (bus.arvalid) begin
            mon_ar++;
            if (bus.araddr !== exp_addr) mon_unstable++;
        end
        if (bus.bvalid && bus.bready) mon_b++;
        if (bus.rvalid && bus.rready) mon_r++;
    end

    int base_aw, base_w, base_b, base_ar, base_r, base_unst;

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        exp_addr = a; exp_wdata = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        base_aw = mon_aw; base_w = mon_w; base_b = mon_b;
        base_ar = mon_ar; base_r = mon_r; base_unst = mon_unstable;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, output bit ok);
        send_cmd(wr, a, d, s);
        wait_rsp(ok);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] hs;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        hs = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid};
        n_cmp++; if (hs !== 6'b0) begin n_bad++; $display("FAIL rst_handshake: got %b want 000000", hs); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++;
        if (rsp_cycles !== '0 || rsp_rdata !== '0 || rsp_write !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rsp_regs: got cyc=%0d rdata=%h wr=%b want 0/0/0", rsp_cycles, rsp_rdata, rsp_write);
        end
        n_cmp++;
        if (bus.awaddr !== '0 || bus.wdata !== '0 || bus.wstrb !== '0) begin
            n_bad++;
            $display("FAIL rst_bus_regs: got addr=%h data=%h strb=%h want 0", bus.awaddr, bus.wdata, bus.wstrb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        bit ok;
        do_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_timeout: got no rsp_valid want rsp_valid"); end
        n_cmp++; if (rsp_write !== 1'b1) begin n_bad++; $display("FAIL wr_rsp_write: got %b want 1", rsp_write); end
        n_cmp++; if (rsp_cycles !== 4'd3) begin n_bad++; $display("FAIL wr_cycles: got %0d want 3", rsp_cycles); end
        n_cmp++;
        if (mon_aw - base_aw != 1 || mon_w - base_w != 1 || mon_b - base_b != 1) begin
            n_bad++;
            $display("FAIL wr_channels: got aw=%0d w=%0d b=%0d want 1/1/1",
                     mon_aw - base_aw, mon_w - base_w, mon_b - base_b);
        end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rsp_cmd_ready: got %b want 0", cmd_ready); end
        ack_rsp();
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_ack: got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
        end
        do_txn(1'b0, 8'h10, 32'h0, 4'h0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_timeout: got no rsp_valid want rsp_valid"); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
        n_cmp++; if (rsp_write !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_write: got %b want 0", rsp_write); end
        n_cmp++; if (rsp_cycles !== 4'd3) begin n_bad++; $display("FAIL rd_cycles: got %0d want 3", rsp_cycles); end
        n_cmp++;
        if (mon_ar - base_ar != 1 || mon_r - base_r != 1) begin
            n_bad++;
            $display("FAIL rd_channels: got ar=%0d r=%0d want 1/1", mon_ar - base_ar, mon_r - base_r);
        end
        ack_rsp();
    endtask

    task automatic test_partial_strobe();
        bit ok;
        do_txn(1'b1, 8'h04, 32'h11223344, 4'hF, ok);
        n_cmp++; if (rsp_rdata !== '0) begin n_bad++; $display("FAIL wr_rdata_zero: got %h want 0", rsp_rdata); end
        ack_rsp();
        do_txn(1'b1, 8'h04, 32'hAABBCCDD, 4'h5, ok);
        ack_rsp();
        do_txn(1'b1, 8'h04, 32'hFFFFFFFF, 4'h0, ok);
        n_cmp++;
        if (!ok || mon_w - base_w != 1 || mon_b - base_b != 1) begin
            n_bad++;
            $display("FAIL strb0_issued: got ok=%b w=%0d b=%0d want 1/1/1", ok, mon_w - base_w, mon_b - base_b);
        end
        ack_rsp();
        do_txn(1'b0, 8'h04, 32'h0, 4'h0, ok);
        n_cmp++; if (rsp_rdata !== 32'h11BB33DD) begin n_bad++; $display("FAIL strb_merge: got %h want 11bb33dd", rsp_rdata); end
        ack_rsp();
    endtask

    task automatic test_skewed();
        bit ok;
        aw_wait = 4;
        do_txn(1'b1, 8'h08, 32'hCAFEF00D, 4'hF, ok);
        aw_wait = 0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL skew_timeout: got no rsp_valid want rsp_valid"); end
        n_cmp++;
        if (mon_aw - base_aw != 5 || mon_w - base_w != 1) begin
            n_bad++;
            $display("FAIL skew_valid_len: got aw=%0d w=%0d want 5/1", mon_aw - base_aw, mon_w - base_w);
        end
        n_cmp++;
        if (mon_b - base_b != 1 || mon_unstable != base_unst) begin
            n_bad++;
            $display("FAIL skew_b_stable: got b=%0d unstable=%0d want 1/0", mon_b - base_b, mon_unstable - base_unst);
        end
        n_cmp++; if (rsp_cycles !== 4'd7) begin n_bad++; $display("FAIL skew_cycles: got %0d want 7", rsp_cycles); end
        ack_rsp();
        do_txn(1'b0, 8'h08, 32'h0, 4'h0, ok);
        n_cmp++; if (rsp_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL skew_readback: got %h want cafef00d", rsp_rdata); end
        ack_rsp();
    endtask

    task automatic test_saturation();
        bit ok;
        aw_wait = 20;  // 23 clocks of latency against a 4-bit counter
        do_txn(1'b1, 8'h0C, 32'h01020304, 4'hF, ok);
        aw_wait = 0;
        n_cmp++; if (mon_aw - base_aw != 21) begin n_bad++; $display("FAIL sat_aw_len: got %0d want 21", mon_aw - base_aw); end
        n_cmp++; if (rsp_cycles !== 4'd15) begin n_bad++; $display("FAIL sat_cycles: got %0d want 15", rsp_cycles); end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        do_txn(1'b1, 8'h20, 32'h5A5AA5A5, 4'hF, ok);
        ack_rsp();
        do_txn(1'b0, 8'h20, 32'h0, 4'h0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: got no rsp_valid want rsp_valid"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5AA5A5 || rsp_cycles !== 4'd3) bad++;
            if (cmd_ready !== 1'b0) bad++;
            cmd_valid = (i >= 2 && i < 5); cmd_write = 1'b0; cmd_addr = 8'h30;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        n_cmp++; if (mon_ar - base_ar != 1) begin n_bad++; $display("FAIL bp_no_ar: got %0d arvalid cycles want 1", mon_ar - base_ar); end
        ack_rsp();
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || bus.arvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_dropped: got ready=%b arvalid=%b want 1/0", cmd_ready, bus.arvalid);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        logic [5:0] hs;
        aw_wait = 10;
        send_cmd(1'b1, 8'h0C, 32'h0BAD0BAD, 4'hF);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_pre: got aw=%b w=%b b=%b want 1/0/0", bus.awvalid, bus.wvalid, bus.bready);
        end
        rst_n = 1'b0;
        #1;
        hs = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid};
        n_cmp++; if (hs !== 6'b0) begin n_bad++; $display("FAIL midrst_async: got %b want 000000", hs); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        aw_wait = 0;
        do_txn(1'b0, 8'h10, 32'h0, 4'h0, ok);
        n_cmp++;
        if (!ok || rsp_rdata !== 32'hDEADBEEF || rsp_cycles !== 4'd3) begin
            n_bad++;
            $display("FAIL midrst_read: got ok=%b rdata=%h cyc=%0d want 1/deadbeef/3", ok, rsp_rdata, rsp_cycles);
        end
        ack_rsp();
        do_txn(1'b0, 8'h0C, 32'h0, 4'h0, ok);
        n_cmp++; if (rsp_rdata !== 32'h01020304) begin n_bad++; $display("FAIL midrst_no_write: got %h want 01020304", rsp_rdata); end
        ack_rsp();
    endtask

    task automatic test_spurious();
        bit ok;
        int bad;
        @(negedge clk);
        spur_b = 1'b1;
        spur_r = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.bready !== 1'b0 || bus.rready !== 1'b0) bad++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        spur_b = 1'b0;
        spur_r = 1'b0;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL spurious_idle: got %0d bad cycles want 0", bad); end
        do_txn(1'b0, 8'h04, 32'h0, 4'h0, ok);
        n_cmp++;
        if (!ok || rsp_rdata !== 32'h11BB33DD || rsp_cycles !== 4'd3) begin
            n_bad++;
            $display("FAIL spurious_after: got ok=%b rdata=%h cyc=%0d want 1/11bb33dd/3", ok, rsp_rdata, rsp_cycles);
        end
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_skewed();
        test_saturation();
        test_backpressure();
        test_reset_mid_write();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
